dmem_mmio: RTL and testbench

//  Data-side memory system for the single-cycle ARM core. Consumes MemWrite/ALUResult/WriteData and returns ReadData.

---
 rtl/mmio_pkg.sv | 54 +++++
 rtl/tx_fifo.sv | 47 ++++
 rtl/dmem_mmio.sv | 112 +++++++++++
 tb/tb_dmem_mmio.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Address map, TXSTAT bit layout and region decode shared by the data-side memory system.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h400;
    localparam logic [31:0] OFF_LED     = 32'h00;
    localparam logic [31:0] OFF_SW      = 32'h04;
    localparam logic [31:0] OFF_TCOUNT  = 32'h08;
    localparam logic [31:0] OFF_TCMP    = 32'h0C;
    localparam logic [31:0] OFF_TSTAT   = 32'h10;
    localparam logic [31:0] OFF_TXDATA  = 32'h14;
    localparam logic [31:0] OFF_TXSTAT  = 32'h18;

    localparam logic [31:0] ADDR_LED    = MMIO_BASE + OFF_LED;
    localparam logic [31:0] ADDR_SW     = MMIO_BASE + OFF_SW;
    localparam logic [31:0] ADDR_TCOUNT = MMIO_BASE + OFF_TCOUNT;
    localparam logic [31:0] ADDR_TCMP   = MMIO_BASE + OFF_TCMP;
    localparam logic [31:0] ADDR_TSTAT  = MMIO_BASE + OFF_TSTAT;
    localparam logic [31:0] ADDR_TXDATA = MMIO_BASE + OFF_TXDATA;
    localparam logic [31:0] ADDR_TXSTAT = MMIO_BASE + OFF_TXSTAT;

    localparam int TXS_FULL   = 0;
    localparam int TXS_EMPTY  = 1;
    localparam int TXS_CNT_LO = 2;
    localparam int TXS_CNT_HI = 4;
    localparam int TXS_OVF    = 5;

    typedef enum logic [3:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_TCOUNT,
        REG_TCMP,
        REG_TSTAT,
        REG_TXDATA,
        REG_TXSTAT,
        REG_NONE
    } region_e;

    // Decode works on the word address since the byte offset never matters.
    function automatic region_e decode_addr(input logic [29:0] waddr, input int ram_words);
        if (waddr < 30'(ram_words)) return REG_RAM;
        case (waddr)
            ADDR_LED[31:2]:    return REG_LED;
            ADDR_SW[31:2]:     return REG_SW;
            ADDR_TCOUNT[31:2]: return REG_TCOUNT;
            ADDR_TCMP[31:2]:   return REG_TCMP;
            ADDR_TSTAT[31:2]:  return REG_TSTAT;
            ADDR_TXDATA[31:2]: return REG_TXDATA;
            ADDR_TXSTAT[31:2]: return REG_TXSTAT;
            default:           return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small circular byte FIFO; callers guarantee no push when full without a pop, and no pop when empty.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dmem_mmio.sv
// Data memory plus memory-mapped LED, switch, compare timer and TX FIFO for the single-cycle core.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int DMEM_WORDS = 64,
    parameter int LED_W      = 8,
    parameter int SW_W       = 8,
    parameter int TX_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [SW_W-1:0]   sw_i,
    output logic [LED_W-1:0]  led_o,
    output logic              timer_irq_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);
    localparam int RAW = $clog2(DMEM_WORDS);

    region_e                    region;
    logic [31:0]                ram [DMEM_WORDS];
    logic [LED_W-1:0]           led;
    logic [SW_W-1:0]            sw_meta, sw_sync;
    logic [31:0]                tcount, tcmp;
    logic                       flag, ovf, match;
    logic                       push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(TX_DEPTH):0]  fifo_count;
    logic [31:0]                cnt32;
    logic [31:0]                txstat;
    logic                       unused_addr_lsbs;

    assign unused_addr_lsbs = ^Addr[1:0];
    assign region   = decode_addr(Addr[31:2], DMEM_WORDS);
    assign match    = (tcmp != '0) && (tcount == tcmp);
    assign push_req = MemWrite && (region == REG_TXDATA);
    assign fifo_pop = tx_valid_o && tx_ready_i;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);

    always_ff @(posedge clk) begin
        if (MemWrite && region == REG_RAM) ram[Addr[RAW+1:2]] <= WriteData;
    end

    // Flag and overflow are sticky; a same-cycle set beats the write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            tcount  <= '0;
            tcmp    <= '0;
            flag    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
            if (MemWrite && region == REG_LED) led <= WriteData[LED_W-1:0];
            if (MemWrite && region == REG_TCMP) tcmp <= WriteData;
            if ((MemWrite && region == REG_TCOUNT) || match) tcount <= '0;
            else tcount <= tcount + 32'd1;
            if (match) flag <= 1'b1;
            else if (MemWrite && region == REG_TSTAT && WriteData[0]) flag <= 1'b0;
            if (push_req && fifo_full && !fifo_pop) ovf <= 1'b1;
            else if (MemWrite && region == REG_TXSTAT && WriteData[TXS_OVF]) ovf <= 1'b0;
        end
    end

    tx_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (WriteData[7:0]),
        .head  (tx_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cnt32 = 32'(fifo_count);

    always_comb begin
        txstat = '0;
        txstat[TXS_FULL]  = fifo_full;
        txstat[TXS_EMPTY] = fifo_empty;
        txstat[TXS_CNT_HI:TXS_CNT_LO] = (cnt32 > 32'd7) ? 3'd7 : cnt32[2:0];
        txstat[TXS_OVF]   = ovf;
    end

    always_comb begin
        ReadData = '0;
        case (region)
            REG_RAM:    ReadData = ram[Addr[RAW+1:2]];
            REG_LED:    ReadData = 32'(led);
            REG_SW:     ReadData = 32'(sw_sync);
            REG_TCOUNT: ReadData = tcount;
            REG_TCMP:   ReadData = tcmp;
            REG_TSTAT:  ReadData = {31'd0, flag};
            REG_TXSTAT: ReadData = txstat;
            default:    ReadData = '0;
        endcase
    end

    assign led_o       = led;
    assign timer_irq_o = flag;
    assign tx_valid_o  = !fifo_empty;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a queue/array model, a negedge monitor compares.
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tb_sw;
    logic [7:0]  led_o;
    logic        timer_irq_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tb_rdy;

    int checks   = 0;
    int failures = 0;

    dmem_mmio dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .Addr        (Addr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .sw_i        (tb_sw),
        .led_o       (led_o),
        .timer_irq_o (timer_irq_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tb_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] rd;
        logic [7:0]  led;
        bit          irq;
        bit          valid;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_led;
    logic [7:0]  sw_hist[$];
    logic [31:0] m_tcount, m_tcmp;
    bit          m_flag, m_ovf;
    logic [7:0]  fq[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelReset();
        m_ram.delete();
        m_led = 8'h00;
        sw_hist = '{8'h00, 8'h00};
        m_tcount = 32'd0;
        m_tcmp = 32'd0;
        m_flag = 1'b0;
        m_ovf = 1'b0;
        fq.delete();
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] addr, output bit known);
        logic [31:0] a;
        int          n;
        a = {addr[31:2], 2'b00};
        known = 1'b1;
        n = (fq.size() > 7) ? 7 : fq.size();
        if (a < 32'h100) begin
            if (m_ram.exists(int'(a >> 2))) return m_ram[int'(a >> 2)];
            known = 1'b0;
            return 32'd0;
        end
        case (a)
            32'h400: return {24'd0, m_led};
            32'h404: return {24'd0, sw_hist[sw_hist.size()-2]};
            32'h408: return m_tcount;
            32'h40C: return m_tcmp;
            32'h410: return {31'd0, m_flag};
            32'h418: return {26'd0, m_ovf, 3'(n), fq.size() == 0, fq.size() == 4};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        logic [31:0] a;
        bit          we, match, pop, pushreq, full;
        a = {Addr[31:2], 2'b00};
        we = MemWrite;
        match = (m_tcmp != 0) && (m_tcount == m_tcmp);
        pop = (fq.size() > 0) && tb_rdy;
        pushreq = we && (a == 32'h414);
        full = (fq.size() == 4);
        if ((we && a == 32'h408) || match) m_tcount = 32'd0;
        else m_tcount = m_tcount + 32'd1;
        if (match) m_flag = 1'b1;
        else if (we && a == 32'h410 && WriteData[0]) m_flag = 1'b0;
        if (we && a == 32'h40C) m_tcmp = WriteData;
        if (pop) void'(fq.pop_front());
        if (pushreq && (!full || pop)) fq.push_back(WriteData[7:0]);
        if (pushreq && full && !pop) m_ovf = 1'b1;
        else if (we && a == 32'h418 && WriteData[5]) m_ovf = 1'b0;
        if (we && a == 32'h400) m_led = WriteData[7:0];
        if (we && a < 32'h100) m_ram[int'(a >> 2)] = WriteData;
        sw_hist.push_back(tb_sw);
        if (sw_hist.size() > 3) void'(sw_hist.pop_front());
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        bit   known;
        MemWrite = we;
        Addr = addr;
        WriteData = wd;
        e.rd = modelRead(addr, known);
        e.chk_rd = known;
        e.name = $sformatf("rd_%08h", addr);
        e.led = m_led;
        e.irq = m_flag;
        e.valid = fq.size() > 0;
        e.data = (fq.size() > 0) ? fq[0] : 8'h00;
        exp_q.push_back(e);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, addr, wd);
    endtask

    task automatic rd(input logic [31:0] addr);
        applyStimulus(1'b0, addr, $urandom);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_rd) checkOutput(mon_e.name, ReadData, mon_e.rd);
            checkOutput("led_o", 32'(led_o), 32'(mon_e.led));
            checkOutput("timer_irq_o", 32'(timer_irq_o), 32'(mon_e.irq));
            checkOutput("tx_valid_o", 32'(tx_valid_o), 32'(mon_e.valid));
            checkOutput("tx_data_o", 32'(tx_data_o), 32'(mon_e.data));
        end
    end

    initial begin
        logic [31:0] ra, rwd;
        int          sel;
        reset = 1'b1;
        MemWrite = 1'b0;
        Addr = 32'd0;
        WriteData = 32'd0;
        tb_sw = 8'h00;
        tb_rdy = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        rd(32'h418);
        rd(32'h400);

        wr(32'h10, 32'hDEADBEEF);
        wr(32'h14, 32'h12345678);
        rd(32'h10);
        rd(32'h14);
        rd(32'h800);
        wr(32'h10, 32'h00000011);
        rd(32'h10);

        wr(32'h408, 32'd0);
        wr(32'h40C, 32'd5);
        repeat (8) rd(32'h410);
        wr(32'h410, 32'd1);
        repeat (14) rd(32'h408);

        tb_rdy = 1'b0;
        foreach (fq[i]) rd(32'h418);
        wr(32'h414, 32'hA1);
        wr(32'h414, 32'hA2);
        wr(32'h414, 32'hA3);
        wr(32'h414, 32'hA4);
        wr(32'h414, 32'hA5);
        rd(32'h418);
        tb_rdy = 1'b1;
        repeat (5) rd(32'h418);

        tb_rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h414, 32'hB1 + i);
        tb_rdy = 1'b1;
        wr(32'h414, 32'hB0);
        tb_rdy = 1'b0;
        rd(32'h418);
        wr(32'h418, 32'h20);
        tb_rdy = 1'b1;
        repeat (6) rd(32'h418);

        tb_sw = 8'h5A;
        rd(32'h404);
        rd(32'h404);
        rd(32'h404);
        wr(32'h400, 32'h1FF);
        rd(32'h400);

        tb_rdy = 1'b0;
        wr(32'h400, 32'h3C);
        wr(32'h414, 32'h01);
        wr(32'h414, 32'h02);
        wr(32'h414, 32'h03);
        rd(32'h418);
        #3 reset = 1'b1;
        #1;
        checkOutput("rst_led_o", 32'(led_o), 32'd0);
        checkOutput("rst_tx_valid_o", 32'(tx_valid_o), 32'd0);
        checkOutput("rst_tx_data_o", 32'(tx_data_o), 32'd0);
        checkOutput("rst_irq", 32'(timer_irq_o), 32'd0);
        modelReset();
        @(posedge clk);
        #1 reset = 1'b0;
        rd(32'h418);
        rd(32'h404);

        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 11);
            rwd = $urandom;
            case (sel)
                0, 1:    ra = {24'd0, 4'($urandom_range(0, 15)), 2'b00} | ((sel == 1) ? 32'hC0 : 32'h0);
                2:       ra = 32'h400;
                3:       ra = 32'h404;
                4:       ra = 32'h408;
                5:       begin ra = 32'h40C; rwd = $urandom_range(0, 12); end
                6:       ra = 32'h410;
                7, 8:    ra = 32'h414;
                9:       ra = 32'h418;
                10:      ra = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h41C;
                default: ra = 32'hFC;
            endcase
            ra = ra | 32'($urandom_range(0, 3));
            tb_rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) tb_sw = 8'($urandom);
            applyStimulus($urandom_range(0, 1) == 1, ra, rwd);
        end

        MemWrite = 1'b0;
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
